rng_share_arbiter: RTL and testbench
====================================

Name: rng_share_arbiter

Overview:
- Shares the single 9-bit pseudo-random generator of the FallingCubes game between several consumers: cube column spawner, colour picker, fall-speed jitter and spare.
- Round-robin arbitration among level requests; one-cycle grant pulse with the captured random value.
- Drives the generator's step enable so each consumer gets a value followed by a configurable number of decorrelating generator steps.
- Sits between the random generator and the game-logic FSMs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- STEPS, 3, generator steps issued after every grant (1..15; 0 illegal).
- LIMIT, 10, exclusive upper bound on delivered values (RNG_RANGE_EN only; 1..511).
- MAX_TRIES, 7, rejection retries before fallback (RNG_RANGE_EN only; 1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req  in  NREQ  level request per consumer.
- rng_value  in  9  current generator output.
- rng_step  out  1  generator advance enable, one step per high cycle.
- gnt  out  NREQ  one-hot grant pulse, 1 cycle.
- rnd_out  out  9  value delivered with gnt; holds until next grant.
- rnd_valid  out  1  high in the same cycle as gnt.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: state=IDLE, gnt=0, rnd_out=0, rnd_valid=0, rng_step=0, busy=0.
  - Pointer last=NREQ-1, so req[0] has first priority.
  - Reset mid-operation aborts at once; no partial grant or step is issued after the reset edge.
- All outputs are registered. rng_step is low except in STIR and REDRAW.
- IDLE:
  - If req != 0, pick the first set bit searching from last+1 upward, wrapping modulo NREQ.
  - Latch it as win; last<=win; go to DRAW.
  - If req == 0, stay in IDLE.
- DRAW:
  - rng_value is stable here because rng_step is low.
  - At the edge: gnt<=onehot(win), rnd_valid<=1, rnd_out<=rng_value, rng_step<=1, cnt<=STEPS-1, then go to STIR.
- STIR:
  - gnt and rnd_valid are 0 from the second STIR cycle on.
  - rng_step is high for exactly STEPS consecutive cycles, starting in the cycle gnt is visible.
  - When cnt==0, at the edge: rng_step<=0 and go to IDLE. Otherwise cnt<=cnt-1.
- Latency and throughput:
  - req sampled in IDLE at cycle N gives gnt at N+2.
  - Minimum grant spacing is STEPS+2 cycles.
- Boundary cases:
  - A winner dropping req during DRAW/STIR still receives its grant; requests are not re-checked.
  - A requester holding req continuously is re-granted only after every other active requester has been served.
  - A single active requester is granted every STEPS+2 cycles.
  - Requests arriving while busy wait; there is no queueing beyond the level req.
  - rng_value==0 is passed through unchanged.

Optional Feature:
- Macro: RNG_RANGE_EN.
- With RNG_RANGE_EN defined:
  - DRAW accepts only when rng_value < LIMIT.
  - Otherwise it goes to REDRAW: rng_step=1 for one cycle, tries<=tries+1, then back to DRAW.
  - After MAX_TRIES rejections, DRAW grants with rnd_out=LIMIT-1 (fallback).
  - tries clears on each grant and on reset.
  - Grant latency becomes 2+2*rejections cycles.
- Without RNG_RANGE_EN: no REDRAW state and no tries counter; LIMIT and MAX_TRIES are ignored; rnd_out is the raw 9-bit value.

Test Plan:
- Reset, then req=4'b0001 for one cycle with rng_value=9'h0A5 → gnt=0001 and rnd_out=0A5 at cycle +2; rng_step high exactly 3 cycles; busy low again at cycle +5.
- req=4'b1111 held, rng_value from a counter model → grant order 0,1,2,3,0; gnt spacing exactly 5 cycles; never two gnt bits set.
- Only req[2] held for 20 cycles → gnt[2] every 5 cycles, 4 grants; rng_step duty 3/5.
- Assert reset during STIR (2nd step cycle) → next cycle all outputs 0; with req=0010 afterwards, first grant goes to req[1] at +2.
- req[1] pulsed 1 cycle, then dropped during DRAW → gnt[1] still issued with the DRAW-cycle rng_value.
- With RNG_RANGE_EN, LIMIT=10, rng_value sequence 300,12,7 → two REDRAW steps, gnt at +6, rnd_out=7. With rng_value fixed at 400 → 7 rejections, then rnd_out=9.

Source files
------------

// File: rtl/rng_share_arbiter.sv
// Round-robin sharing of the 9-bit FallingCubes random generator among NREQ consumers.
// Optional RNG_RANGE_EN: rejection sampling into [0, LIMIT) with fallback after MAX_TRIES.
module rng_share_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned STEPS     = 3,
  parameter int unsigned LIMIT     = 10,
  parameter int unsigned MAX_TRIES = 7
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [NREQ-1:0] req_i,
  input  logic [8:0]      rng_value_i,
  output logic            rng_step_o,
  output logic [NREQ-1:0] gnt_o,
  output logic [8:0]      rnd_out_o,
  output logic            rnd_valid_o,
  output logic            busy_o
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 4;
  localparam int unsigned RW = 9;

  // Elaboration-time parameter sanity.
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("rng_share_arbiter: NREQ out of range");
  end
  if (STEPS < 1 || STEPS > 15) begin : g_bad_steps
    $error("rng_share_arbiter: STEPS out of range");
  end
  if (LIMIT < 1 || LIMIT > 511 || MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_range
    $error("rng_share_arbiter: LIMIT/MAX_TRIES out of range");
  end

`ifdef RNG_RANGE_EN
  localparam int unsigned TW = 4;
  localparam logic [RW-1:0] LIM      = RW'(LIMIT);
  localparam logic [RW-1:0] FALLBACK = RW'(LIMIT - 1);
  localparam logic [TW-1:0] TRY_MAX  = TW'(MAX_TRIES);
  typedef enum logic [1:0] {IDLE, DRAW, STIR, REDRAW} state_t;
  logic [TW-1:0] tries_q, tries_d;
  logic          accept_c;
`else
  typedef enum logic [1:0] {IDLE, DRAW, STIR} state_t;
`endif

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   win_c;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [RW-1:0]   rnd_out_q, rnd_out_d;
  logic [RW-1:0]   grant_val_c;
  logic            rnd_valid_q, rnd_valid_d;
  logic            rng_step_q, rng_step_d;
  logic            busy_q, busy_d;
  logic            do_grant_c;

  // Round-robin search starting one past the last winner.
  always_comb begin
    int unsigned idx;
    logic        found;
    win_c = last_q;
    found = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(last_q) + i) % NREQ;
      if (!found && req_i[IW'(idx)]) begin
        found = 1'b1;
        win_c = IW'(idx);
      end
    end
  end

`ifdef RNG_RANGE_EN
  always_comb begin
    accept_c    = (rng_value_i < LIM);
    do_grant_c  = accept_c || (tries_q == TRY_MAX);
    grant_val_c = accept_c ? rng_value_i : FALLBACK;
  end
`else
  always_comb begin
    do_grant_c  = 1'b1;
    grant_val_c = rng_value_i;
  end
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rnd_valid_d = 1'b0;
    rnd_out_d   = rnd_out_q;
    rng_step_d  = 1'b0;
`ifdef RNG_RANGE_EN
    tries_d     = tries_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          win_d   = win_c;
          last_d  = win_c;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (do_grant_c) begin
          gnt_d       = NREQ'(1) << win_q;
          rnd_valid_d = 1'b1;
          rnd_out_d   = grant_val_c;
          rng_step_d  = 1'b1;
          cnt_d       = CW'(STEPS - 1);
          state_d     = STIR;
`ifdef RNG_RANGE_EN
          tries_d     = '0;
        end else begin
          rng_step_d  = 1'b1;
          tries_d     = tries_q + TW'(1);
          state_d     = REDRAW;
`endif
        end
      end
      STIR: begin
        // The step already visible this cycle is the last one when cnt hits zero.
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d      = cnt_q - CW'(1);
          rng_step_d = 1'b1;
        end
      end
`ifdef RNG_RANGE_EN
      REDRAW: state_d = DRAW;
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      last_q      <= IW'(NREQ - 1);
      win_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rnd_out_q   <= '0;
      rnd_valid_q <= 1'b0;
      rng_step_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef RNG_RANGE_EN
      tries_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rnd_out_q   <= rnd_out_d;
      rnd_valid_q <= rnd_valid_d;
      rng_step_q  <= rng_step_d;
      busy_q      <= busy_d;
`ifdef RNG_RANGE_EN
      tries_q     <= tries_d;
`endif
    end
  end

  assign gnt_o       = gnt_q;
  assign rnd_out_o   = rnd_out_q;
  assign rnd_valid_o = rnd_valid_q;
  assign rng_step_o  = rng_step_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Scoreboard bench for rng_share_arbiter: stimulus queues expected grants, a monitor checks them.
module tb_rng_share_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [8:0] rng_value;
  logic       rng_step_o;
  logic [3:0] gnt_o;
  logic [8:0] rnd_out_o;
  logic       rnd_valid_o;
  logic       busy_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit auto_rng = 1'b0;

  typedef struct {
    logic [3:0] gnt;
    logic [8:0] rnd;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  rng_share_arbiter #(.NREQ(4), .STEPS(3), .LIMIT(10), .MAX_TRIES(7)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_i       (req),
    .rng_value_i (rng_value),
    .rng_step_o  (rng_step_o),
    .gnt_o       (gnt_o),
    .rnd_out_o   (rnd_out_o),
    .rnd_valid_o (rnd_valid_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [8:0] r, input int cy);
    exp_t e;
    e.gnt = g;
    e.rnd = r;
    e.cyc = cy;
    exp_q.push_back(e);
  endtask

  // Inputs change on the falling edge; the generator model advances once per step cycle.
  task automatic tick();
    @(negedge clk);
    if (auto_rng && rng_step_o) rng_value = rng_value + 9'd1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    req   = '0;
    tick();
    reset = 1'b0;
  endtask

  // Monitor: every presented grant must match the head of the expectation queue.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (gnt_o != '0 || rnd_valid_o) begin
      chk("gnt_onehot", 32'($countones(gnt_o)), 32'd1);
      chk("rnd_valid_with_gnt", 32'(rnd_valid_o), 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant actual gnt=%b rnd=%0h expected none (cycle %0d)",
                 gnt_o, rnd_out_o, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("gnt", 32'(gnt_o), 32'(e.gnt));
        chk("rnd_out", 32'(rnd_out_o), 32'(e.rnd));
        chk("gnt_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int c;
    int steps;
    reset     = 1'b1;
    req       = '0;
    rng_value = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_rnd_out", 32'(rnd_out_o), 32'd0);
    chk("rst_rnd_valid", 32'(rnd_valid_o), 32'd0);
    chk("rst_rng_step", 32'(rng_step_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    reset = 1'b0;

`ifdef RNG_RANGE_EN
    // Rejections 300 and 12, accept 7.
    tick();
    c = cyc; req = 4'b0001; rng_value = 9'd300;
    push(4'b0001, 9'd7, c + 6);
    steps = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      steps += int'(rng_step_o);
      if (k == 1) req = '0;
      if (k == 2) rng_value = 9'd12;
      if (k == 4) rng_value = 9'd7;
    end
    chk("range_steps", 32'(steps), 32'd5);

    // Constant 400 exhausts the retries and falls back to LIMIT-1.
    do_reset();
    c = cyc; req = 4'b0001; rng_value = 9'd400;
    push(4'b0001, 9'd9, c + 16);
    tick();
    req = '0;
    for (int k = 0; k < 22; k++) tick();
    chk("fallback_idle", 32'(busy_o), 32'd0);
`else
    // Single pulse: latency, step count, busy window.
    tick();
    c = cyc; req = 4'b0001; rng_value = 9'h0A5;
    push(4'b0001, 9'h0A5, c + 2);
    steps = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin
        req = '0;
        chk("busy_in_draw", 32'(busy_o), 32'd1);
      end
      if (k == 5) chk("busy_low_after", 32'(busy_o), 32'd0);
      steps += int'(rng_step_o);
    end
    chk("step_count", 32'(steps), 32'd3);

    // All four requesting: rotation 0,1,2,3,0 at 5-cycle spacing.
    do_reset();
    c = cyc; req = 4'b1111; rng_value = 9'h010; auto_rng = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push(4'(1 << (k % 4)), 9'(9'h010 + 9'(3 * k)), c + 2 + 5 * k);
    end
    for (int k = 1; k <= 21; k++) tick();
    req = '0;
    for (int k = 0; k < 8; k++) tick();

    // Lone requester 2 held 20 cycles: four grants, step duty 12/20.
    do_reset();
    c = cyc; req = 4'b0100; rng_value = 9'h100;
    for (int k = 0; k < 4; k++) push(4'b0100, 9'(9'h100 + 9'(3 * k)), c + 2 + 5 * k);
    steps = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      steps += int'(rng_step_o);
      if (k == 20) req = '0;
    end
    chk("lone_step_duty", 32'(steps), 32'd12);
    for (int k = 0; k < 6; k++) tick();
    auto_rng = 1'b0;

    // Reset in the second step cycle aborts; requester 1 is then served at +2.
    c = cyc; req = 4'b0001; rng_value = 9'h033;
    push(4'b0001, 9'h033, c + 2);
    tick();
    req = '0;
    tick();
    tick();
    chk("stir_step_before_reset", 32'(rng_step_o), 32'd1);
    reset = 1'b1;
    tick();
    chk("abort_gnt", 32'(gnt_o), 32'd0);
    chk("abort_rnd_out", 32'(rnd_out_o), 32'd0);
    chk("abort_rnd_valid", 32'(rnd_valid_o), 32'd0);
    chk("abort_rng_step", 32'(rng_step_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    reset = 1'b0;
    c = cyc; req = 4'b0010; rng_value = 9'h0C3;
    push(4'b0010, 9'h0C3, c + 2);
    tick();
    req = '0;
    for (int k = 0; k < 6; k++) tick();

    // Pulse dropped during DRAW still granted, with the DRAW value (zero passes through).
    c = cyc; req = 4'b0010; rng_value = 9'h0AA;
    push(4'b0010, 9'h000, c + 2);
    tick();
    req = '0; rng_value = 9'h000;
    for (int k = 0; k < 6; k++) tick();

    // Pointer at 1: requesters 2 and 3 served in that order.
    c = cyc; req = 4'b1100; rng_value = 9'h1F0; auto_rng = 1'b1;
    push(4'b0100, 9'h1F0, c + 2);
    push(4'b1000, 9'h1F3, c + 7);
    for (int k = 1; k <= 6; k++) tick();
    req = '0;
    for (int k = 0; k < 8; k++) tick();
    auto_rng = 1'b0;
`endif

    for (int k = 0; k < 4; k++) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
